alu_seq_ctrl: RTL and testbench
===============================

# alu_seq_ctrl

Multi-cycle sequencer that runs a WIDTH-bit ALU operation through a 2-bit digit slice, least-significant digit first. It latches operands and opcode on a start request and steps the slice once per clock. It chains the carry between steps, accumulates an equality flag, and presents the full-width result with a one-cycle done pulse. It sits between the operand/opcode source and the 2-bit arithmetic datapath, so wide operations reuse a single narrow slice.

## Interface
- WIDTH, 8, operand/result width; must be even and ≥ 2; the step count N = WIDTH/2
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  reset; asynchronous, active-low
- start  in  1  operation request; sampled only in IDLE
- op  in  3  opcode: 000 AND, 001 OR, 010 XOR, 011 NOR, 100 pass A, 101 NOT A, 110 pass B, 111 ADD
- a  in  WIDTH  operand A; sampled with start
- b  in  WIDTH  operand B; sampled with start
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse when the result registers update
- result  out  WIDTH  final result; holds until the next completion
- cout  out  1  carry out of the MSB digit for ADD; 0 for all other ops
- eq  out  1  1 when the latched a equals the latched b (valid for every op)

## Operation
- States: IDLE, RUN, DONE.
- IDLE, start=1: latch a→sa, b→sb, op→sop; carry←0, eq_acc←1, step←0; go to RUN. With start=0, stay in IDLE.
- RUN, each cycle, using digit d = {sa[1:0], sb[1:0]}:
  - ADD: {c, r} = sa[1:0] + sb[1:0] + carry, 3-bit sum; carry←c.
  - Other ops: bitwise on the 2 bits; carry←0.
  - eq_acc ← eq_acc & (sa[1:0]==sb[1:0]).
  - sa and sb shift right by 2. r shifts into the top of the working register wr, so wr shifts right by 2 and r enters at wr[WIDTH-1:WIDTH-2].
  - step increments. When step == N-1, go to DONE; the final digit is included in the update at that edge.
- DONE, single cycle: result←wr, cout←carry (ADD only, else 0), eq←eq_acc, all at the edge entering DONE. done=1 and busy=0 in this cycle. The next state is always IDLE.
- start is ignored in RUN and DONE. It is not queued. a, b and op may change freely after the accepting edge.
- result, cout and eq change only on entry to DONE. They are stable at all other times, including during RUN.
- The step counter is ceil(log2(N)) bits wide, minimum 1. Carry is discarded when a non-ADD op completes.

## Timing
- Reset (asynchronous, any state): state=IDLE; busy=0, done=0, result=0, cout=0, eq=0; internal registers cleared. An in-flight operation is abandoned with no done pulse.
- Reset release: the first start is sampled at the first rising edge with rst_n=1.
- Latency: start is accepted at edge k. busy=1 from edge k through edge k+N-1. State is DONE after edge k+N, so done=1 and outputs are valid in the cycle following edge k+N. State is IDLE after edge k+N+1.
- Throughput: one operation per N+2 cycles. start held continuously high re-triggers in the IDLE cycle after DONE.
- WIDTH=2: a single RUN cycle, then DONE.

## Test plan
- ADD, WIDTH=8, a=0xFF, b=0x01, start pulsed at edge k → done high only after edge k+4; result=0x00, cout=1, eq=0; busy high for exactly 4 cycles.
- ADD a=0x7F, b=0x01 → result=0x80, cout=0. This checks carry propagation across all digit boundaries. Then ADD a=0x55, b=0x55 → result=0xAA, cout=0, eq=1.
- Bitwise: AND 0xA5,0x3C → 0x24; OR → 0xBD; XOR → 0x99; NOR → 0x42; NOT A 0xA5 → 0x5A; pass B → 0x3C. cout=0 and eq=0 in every case.
- Start while busy: start at edge k with op ADD, a=0x10, b=0x20. Assert start again with a=0xFF at edges k+1..k+4. Required: one done at edge k+4 with result=0x30; a second operation is accepted only in the following IDLE cycle.
- Reset mid-run: drop rst_n asynchronously two cycles into RUN → busy, done, result, cout, eq go to 0 immediately with no done pulse. After release, start with XOR 0x0F,0x0F → result=0x00, eq=1.
- Operand change after accept: start with a=0x12, b=0x34 (ADD), then drive a=b=0xFF on the next cycle → result=0x46, cout=0. Outputs stay unchanged during RUN and hold after done until the next completion.

Source files
------------

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: runs a WIDTH-bit ALU op through a 2-bit slice, LSD first.
// Ports: clk, rst_n, start/op/a/b in; busy, done, result, cout, eq out.
module alu_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             eq
);

  localparam int N  = WIDTH / 2;
  localparam int SW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] sa, sb, wr, wr_nx;
  logic [2:0]       sop;
  logic             carry, eq_acc;
  logic [SW-1:0]    step;

  logic [1:0] da, db, r;
  logic [2:0] sum;
  logic       c, last;

  always_comb begin
    da  = sa[1:0];
    db  = sb[1:0];
    sum = {1'b0, da} + {1'b0, db} + {2'b00, carry};
    r   = 2'b00;
    c   = 1'b0;
    unique case (sop)
      3'b000: r = da & db;
      3'b001: r = da | db;
      3'b010: r = da ^ db;
      3'b011: r = ~(da | db);
      3'b100: r = da;
      3'b101: r = ~da;
      3'b110: r = db;
      3'b111: begin
        r = sum[1:0];
        c = sum[2];
      end
      default: r = 2'b00;
    endcase
  end

  // New digit enters at the top; works for WIDTH=2 too.
  assign wr_nx = WIDTH'({r, wr} >> 2);
  assign last  = (step == SW'(N - 1));

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: if (start) state_nx = RUN;
      RUN: begin
        busy = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      sa     <= '0;
      sb     <= '0;
      wr     <= '0;
      sop    <= '0;
      carry  <= 1'b0;
      eq_acc <= 1'b0;
      step   <= '0;
      result <= '0;
      cout   <= 1'b0;
      eq     <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        sa     <= a;
        sb     <= b;
        sop    <= op;
        carry  <= 1'b0;
        eq_acc <= 1'b1;
        step   <= '0;
      end else if (state == RUN) begin
        sa     <= sa >> 2;
        sb     <= sb >> 2;
        wr     <= wr_nx;
        carry  <= c;
        eq_acc <= eq_acc & (da == db);
        step   <= step + 1'b1;
        if (last) begin
          result <= wr_nx;
          cout   <= c;
          eq     <= eq_acc & (da == db);
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: directed vectors for alu_seq_ctrl, WIDTH=8.
// Ports: none; drives the DUT and prints one summary line.
module tb_alu_seq_ctrl;

  localparam int W = 8;
  localparam int N = W / 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   op = 3'b000;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, cout, eq;
  logic [W-1:0] result;

  int checks = 0;
  int errors = 0;

  alu_seq_ctrl #(.WIDTH(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .op(op),
    .a(a),
    .b(b),
    .busy(busy),
    .done(done),
    .result(result),
    .cout(cout),
    .eq(eq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issue one op from a negedge in IDLE; na/nb are driven after accept.
  task automatic do_op(input string tag, input logic [2:0] o,
                       input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [W-1:0] nx, input logic [W-1:0] ny,
                       input logic [W-1:0] er, input logic ec,
                       input logic ee);
    int bcnt;
    int cyc;
    int unstable;
    logic [W-1:0] pr;
    logic pc, pe;
    pr = result;
    pc = cout;
    pe = eq;
    op = o;
    a = x;
    b = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = nx;
    b = ny;
    bcnt = 0;
    cyc = 0;
    unstable = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (busy) bcnt++;
      if (!done && (result !== pr || cout !== pc || eq !== pe))
        unstable++;
    end while (!done && cyc < 20);
    chk({tag, "_lat"}, cyc, N + 1);
    chk({tag, "_busy"}, bcnt, N);
    chk({tag, "_stable"}, unstable, 0);
    chk({tag, "_res"}, result, er);
    chk({tag, "_cout"}, cout, ec);
    chk({tag, "_eq"}, eq, ee);
    @(negedge clk);
    chk({tag, "_pulse"}, {busy, done}, 2'b00);
  endtask

  initial begin
    int cyc;
    int dcnt;
    #12;
    chk("rst_out", {busy, done, result, cout, eq}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle", {busy, done}, 2'b00);

    do_op("add_ff01", 3'b111, 8'hFF, 8'h01, 8'hFF, 8'h01, 8'h00, 1, 0);
    do_op("add_7f01", 3'b111, 8'h7F, 8'h01, 8'h7F, 8'h01, 8'h80, 0, 0);
    do_op("add_5555", 3'b111, 8'h55, 8'h55, 8'h55, 8'h55, 8'hAA, 0, 1);
    do_op("and", 3'b000, 8'hA5, 8'h3C, 8'hA5, 8'h3C, 8'h24, 0, 0);
    do_op("or", 3'b001, 8'hA5, 8'h3C, 8'hA5, 8'h3C, 8'hBD, 0, 0);
    do_op("xor", 3'b010, 8'hA5, 8'h3C, 8'hA5, 8'h3C, 8'h99, 0, 0);
    do_op("nor", 3'b011, 8'hA5, 8'h3C, 8'hA5, 8'h3C, 8'h42, 0, 0);
    do_op("nota", 3'b101, 8'hA5, 8'h3C, 8'hA5, 8'h3C, 8'h5A, 0, 0);
    do_op("passb", 3'b110, 8'hA5, 8'h3C, 8'hA5, 8'h3C, 8'h3C, 0, 0);
    do_op("passa", 3'b100, 8'hA5, 8'h3C, 8'hA5, 8'h3C, 8'hA5, 0, 0);
    do_op("opchg", 3'b111, 8'h12, 8'h34, 8'hFF, 8'hFF, 8'h46, 0, 0);

    repeat (3) @(negedge clk);
    chk("hold", {result, cout, eq}, {8'h46, 1'b0, 1'b0});

    // start held high through RUN/DONE must not queue the 0xFF request
    op = 3'b111;
    a = 8'h10;
    b = 8'h20;
    start = 1'b1;
    @(posedge clk);
    #1;
    a = 8'hFF;
    cyc = 0;
    dcnt = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!done && cyc < 20);
    chk("sbusy_lat", cyc, N + 1);
    chk("sbusy_res", result, 8'h30);
    @(negedge clk);
    chk("sbusy_idle", {busy, done}, 2'b00);
    @(negedge clk);
    chk("sbusy_acc", busy, 1'b1);
    start = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (done) dcnt++;
    end while (!done && cyc < 20);
    chk("sbusy2_cnt", dcnt, 1);
    chk("sbusy2_res", {result, cout}, {8'h1F, 1'b1});
    @(negedge clk);

    // abandon an op mid-run with an asynchronous reset
    op = 3'b111;
    a = 8'h7F;
    b = 8'h01;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_out", {busy, done, result, cout, eq}, '0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (done || busy) dcnt++;
    end
    chk("mrst_quiet", dcnt, 0);
    do_op("xor_0f", 3'b010, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h00, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
